chip_spi_slave: RTL and testbench

Chip-side SPI responder that terminates the 4-wire SPI link driven by the FPGA test master. It oversamples `spi_cs`, `spi_sck` and `spi_mosi` in the chip clock domain and decodes framed burst commands. Write bursts become word writes on an internal memory port. Read bursts fetch words from that port and shift them out on `spi_miso`. It sits inside the chip top, between the pad inputs and the weight/activation storage.

---
 rtl/chip_spi_pkg.sv | 21 ++
 rtl/chip_spi_slave_if.sv | 16 +
 rtl/spi_sync_edge.sv | 31 +++
 rtl/chip_spi_slave.sv | 153 +++++++++++++++
 tb/tb_chip_spi_slave.sv | 270 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/chip_spi_pkg.sv
// Shared definitions for the chip-side SPI responder: header field layout,
// frame state encoding and word size.
package chip_spi_pkg;

  localparam int WORD_BITS = 32;

  localparam int RW_BIT   = 31;
  localparam int LEN_MSB  = 23;
  localparam int LEN_LSB  = 16;
  localparam int ADDR_MSB = 15;
  localparam int ADDR_LSB = 0;

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    WDATA,
    RDATA,
    DONE
  } state_t;

endpackage

// File: rtl/chip_spi_slave_if.sv
// Internal memory port driven by the SPI responder (master side) and served
// by the weight/activation storage (slave side).
interface chip_spi_slave_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
) ();
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;

  modport master (output wr_en, wr_addr, wr_data, rd_en, rd_addr, input rd_data);
  modport slave  (input wr_en, wr_addr, wr_data, rd_en, rd_addr, output rd_data);
endinterface

// File: rtl/spi_sync_edge.sv
// Synchronizer chain for one SPI pad input plus registered edge detect; the
// level output carries the same latency as the edge pulses.
module spi_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_p;

  // Reset to 0 so a CS held low through reset never looks like a fresh fall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_p <= '0;
      level  <= 1'b0;
      rise   <= 1'b0;
      fall   <= 1'b0;
    end else begin
      sync_p <= {sync_p[SYNC_STAGES-2:0], din};
      level  <= sync_p[SYNC_STAGES-1];
      rise   <= sync_p[SYNC_STAGES-1] & ~level;
      fall   <= ~sync_p[SYNC_STAGES-1] & level;
    end
  end

endmodule

// File: rtl/chip_spi_slave.sv
// Chip-side SPI mode-0 responder: decodes framed burst headers and turns them
// into word writes or prefetched word reads on the internal memory port.
module chip_spi_slave
  import chip_spi_pkg::*;
#(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic              CLK,
  input  logic              rst_n,
  input  logic              spi_cs,
  input  logic              spi_sck,
  input  logic              spi_mosi,
  output logic              spi_miso,
  output logic              busy,
  output logic              frame_done,
  output logic              abort,
  chip_spi_slave_if.master  mem
);

  logic cs_rise, cs_fall, cs_lvl_unused;
  logic sck_rise, sck_fall, sck_lvl_unused;
  logic mosi_lvl, mosi_rise_unused, mosi_fall_unused;

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_cs (
    .clk(CLK), .rst_n(rst_n), .din(spi_cs),
    .level(cs_lvl_unused), .rise(cs_rise), .fall(cs_fall));
  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sck (
    .clk(CLK), .rst_n(rst_n), .din(spi_sck),
    .level(sck_lvl_unused), .rise(sck_rise), .fall(sck_fall));
  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_mosi (
    .clk(CLK), .rst_n(rst_n), .din(spi_mosi),
    .level(mosi_lvl), .rise(mosi_rise_unused), .fall(mosi_fall_unused));

  state_t              state, state_nxt;
  logic [4:0]          bit_cnt;
  logic [7:0]          count;
  logic [ADDR_W-1:0]   addr;
  logic [DATA_W-2:0]   rx_sr;
  logic [DATA_W-1:0]   rx_word, tx_sr;
  logic                tx_load;
  logic                word_end;
  logic                wr_en_nxt, rd_en_nxt, frame_done_nxt, abort_nxt;
  logic                wr_en_q, rd_en_q;
  logic [ADDR_W-1:0]   wr_addr_q, rd_addr_q;
  logic [DATA_W-1:0]   wr_data_q;

  assign rx_word  = {rx_sr, mosi_lvl};
  assign word_end = sck_rise && (bit_cnt == 5'(WORD_BITS - 1));
  assign busy     = (state != IDLE);

  assign mem.wr_en   = wr_en_q;
  assign mem.wr_addr = wr_addr_q;
  assign mem.wr_data = wr_data_q;
  assign mem.rd_en   = rd_en_q;
  assign mem.rd_addr = rd_addr_q;

  always_comb begin
    state_nxt      = state;
    wr_en_nxt      = 1'b0;
    rd_en_nxt      = 1'b0;
    frame_done_nxt = 1'b0;
    abort_nxt      = 1'b0;
    case (state)
      IDLE:  if (cs_fall) state_nxt = HDR;
      HDR:   if (word_end) begin
               state_nxt = rx_word[RW_BIT] ? WDATA : RDATA;
               rd_en_nxt = !rx_word[RW_BIT];
             end
      WDATA: if (word_end) begin
               wr_en_nxt = 1'b1;
               if (count == '0) state_nxt = DONE;
             end
      RDATA: if (word_end) begin
               if (count == '0) state_nxt = DONE;
               else             rd_en_nxt = 1'b1;
             end
      DONE:  ;
      default: state_nxt = IDLE;
    endcase
    // CS release overrides any word completing in the same cycle.
    if (state != IDLE && cs_rise) begin
      state_nxt = IDLE;
      wr_en_nxt = 1'b0;
      rd_en_nxt = 1'b0;
      if (state == DONE) frame_done_nxt = 1'b1;
      else               abort_nxt      = 1'b1;
    end
  end

  // Control stage: state, counters, strobes and the memory-port registers.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      count      <= '0;
      addr       <= '0;
      wr_en_q    <= 1'b0;
      rd_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      rd_addr_q  <= '0;
      wr_data_q  <= '0;
      frame_done <= 1'b0;
      abort      <= 1'b0;
      tx_load    <= 1'b0;
      spi_miso   <= 1'b0;
    end else begin
      state      <= state_nxt;
      wr_en_q    <= wr_en_nxt;
      rd_en_q    <= rd_en_nxt;
      frame_done <= frame_done_nxt;
      abort      <= abort_nxt;
      tx_load    <= rd_en_q;

      if (state == IDLE)
        bit_cnt <= '0;
      else if (sck_rise && (state == HDR || state == WDATA || state == RDATA))
        bit_cnt <= bit_cnt + 5'd1;

      if (state == HDR && word_end && !cs_rise) begin
        addr      <= rx_word[ADDR_LSB +: ADDR_W];
        rd_addr_q <= rx_word[ADDR_LSB +: ADDR_W];
        count     <= rx_word[LEN_MSB:LEN_LSB];
      end else if (state == WDATA && wr_en_nxt) begin
        wr_addr_q <= addr;
        wr_data_q <= rx_word;
        addr      <= addr + 1'b1;
        count     <= count - 1'b1;
      end else if (state == RDATA && rd_en_nxt) begin
        addr      <= addr + 1'b1;
        rd_addr_q <= addr + 1'b1;
        count     <= count - 1'b1;
      end

      if (state != RDATA)
        spi_miso <= 1'b0;
      else if (sck_fall)
        spi_miso <= tx_sr[DATA_W-1];
    end
  end

  // Data stage: receive and transmit shift registers.
  always_ff @(posedge CLK) begin
    if (sck_rise)
      rx_sr <= rx_word[DATA_W-2:0];
    if (tx_load)
      tx_sr <= mem.rd_data;
    else if (state == RDATA && sck_fall)
      tx_sr <= {tx_sr[DATA_W-2:0], 1'b0};
  end

endmodule

// File: tb/tb_chip_spi_slave.sv
// Bit-banged SPI master plus a memory model; expected memory-port traffic is
// queued when frames are driven and matched as the strobes appear.
module tb_chip_spi_slave;

  localparam int ADDR_W = 16;
  localparam int HALF   = 8;

  logic CLK = 1'b0;
  logic rst_n = 1'b0;
  logic spi_cs = 1'b1;
  logic spi_sck = 1'b0;
  logic spi_mosi = 1'b0;
  logic spi_miso, busy, frame_done, abort;

  chip_spi_slave_if #(.ADDR_W(ADDR_W), .DATA_W(32)) mem_if ();

  chip_spi_slave #(.ADDR_W(ADDR_W), .DATA_W(32), .SYNC_STAGES(2)) dut (
    .CLK(CLK), .rst_n(rst_n), .spi_cs(spi_cs), .spi_sck(spi_sck),
    .spi_mosi(spi_mosi), .spi_miso(spi_miso), .busy(busy),
    .frame_done(frame_done), .abort(abort), .mem(mem_if.master));

  always #5 CLK = ~CLK;

  int n_vec = 0, n_err = 0;
  int n_wr = 0, n_rd = 0, n_fd = 0, n_ab = 0, n_miso_hi = 0;
  logic [47:0] exp_wr_q[$];
  logic [15:0] exp_rd_q[$];
  logic [47:0] e_wr;
  logic [15:0] e_rd;
  logic [31:0] rx;

  initial mem_if.rd_data = '0;
  always @(posedge CLK)
    if (mem_if.rd_en) mem_if.rd_data <= {16'h0000, mem_if.rd_addr} + 32'h0000_A000;

  always @(negedge CLK) begin
    if (mem_if.wr_en) begin
      n_wr++; n_vec++;
      if (exp_wr_q.size() == 0) begin
        n_err++;
        $display("FAIL wr_unexpected got addr=%h data=%h required no write", mem_if.wr_addr, mem_if.wr_data);
      end else begin
        e_wr = exp_wr_q.pop_front();
        if ({mem_if.wr_addr, mem_if.wr_data} !== e_wr) begin
          n_err++;
          $display("FAIL wr_port got %h/%h required %h/%h", mem_if.wr_addr, mem_if.wr_data, e_wr[47:32], e_wr[31:0]);
        end
      end
    end
    if (mem_if.rd_en) begin
      n_rd++; n_vec++;
      if (exp_rd_q.size() == 0) begin
        n_err++;
        $display("FAIL rd_unexpected got addr=%h required no read", mem_if.rd_addr);
      end else begin
        e_rd = exp_rd_q.pop_front();
        if (mem_if.rd_addr !== e_rd) begin
          n_err++;
          $display("FAIL rd_addr got %h required %h", mem_if.rd_addr, e_rd);
        end
      end
    end
    if (frame_done) n_fd++;
    if (abort) n_ab++;
    if (frame_done && abort) begin
      n_vec++; n_err++;
      $display("FAIL done_abort_excl got both=1 required at most one");
    end
    if (spi_miso) n_miso_hi++;
  end

  task automatic clk_n(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic spi_bits(input logic [31:0] tx, input int nbits, output logic [31:0] rxw);
    rxw = '0;
    for (int i = nbits - 1; i >= 0; i--) begin
      spi_mosi = tx[i];
      clk_n(HALF);
      rxw = {rxw[30:0], spi_miso};
      spi_sck = 1'b1;
      clk_n(HALF);
      spi_sck = 1'b0;
    end
  endtask

  task automatic cs_start();
    spi_cs = 1'b0;
    clk_n(8);
  endtask

  task automatic cs_end();
    clk_n(HALF);
    spi_cs = 1'b1;
    clk_n(12);
  endtask

  task automatic check_idle_counts(input string name, input int fd0, input int ab0,
                                   input int fd_req, input int ab_req);
    n_vec++;
    if (n_fd - fd0 !== fd_req || n_ab - ab0 !== ab_req || busy !== 1'b0) begin
      n_err++;
      $display("FAIL %s end got done=%0d abort=%0d busy=%b required done=%0d abort=%0d busy=0",
               name, n_fd - fd0, n_ab - ab0, busy, fd_req, ab_req);
    end
    n_vec++;
    if (exp_wr_q.size() != 0 || exp_rd_q.size() != 0) begin
      n_err++;
      $display("FAIL %s queues got wr_left=%0d rd_left=%0d required 0/0", name, exp_wr_q.size(), exp_rd_q.size());
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clk_n(4);
    n_vec++;
    if ({spi_miso, mem_if.wr_en, mem_if.rd_en, busy, frame_done, abort} !== 6'b0) begin
      n_err++;
      $display("FAIL reset_strobes got %b required 000000", {spi_miso, mem_if.wr_en, mem_if.rd_en, busy, frame_done, abort});
    end
    n_vec++;
    if ({mem_if.wr_addr, mem_if.rd_addr, mem_if.wr_data} !== 64'h0) begin
      n_err++;
      $display("FAIL reset_bus got %h/%h/%h required 0", mem_if.wr_addr, mem_if.rd_addr, mem_if.wr_data);
    end
    rst_n = 1'b1;
    clk_n(12);
    n_vec++;
    if (busy !== 1'b0 || n_ab !== 0) begin
      n_err++;
      $display("FAIL reset_release got busy=%b aborts=%0d required 0/0", busy, n_ab);
    end
  endtask

  task automatic test_write_burst();
    int fd0 = n_fd, ab0 = n_ab, wr0 = n_wr;
    n_miso_hi = 0;
    exp_wr_q.push_back({16'h0010, 32'hDEADBEEF});
    exp_wr_q.push_back({16'h0011, 32'h12345678});
    cs_start();
    spi_bits(32'h8001_0010, 32, rx);
    n_vec++;
    if (busy !== 1'b1) begin
      n_err++;
      $display("FAIL write_busy got %b required 1", busy);
    end
    spi_bits(32'hDEADBEEF, 32, rx);
    spi_bits(32'h12345678, 32, rx);
    cs_end();
    n_vec++;
    if (n_wr - wr0 !== 2 || n_miso_hi !== 0) begin
      n_err++;
      $display("FAIL write_count got writes=%0d miso_hi=%0d required 2/0", n_wr - wr0, n_miso_hi);
    end
    check_idle_counts("write", fd0, ab0, 1, 0);
  endtask

  task automatic test_read_burst(input logic [15:0] base, input int words, input string name);
    int fd0 = n_fd, ab0 = n_ab;
    logic [31:0] hdr;
    hdr = {8'h00, 8'(words - 1), base};
    for (int w = 0; w < words; w++) exp_rd_q.push_back(base + 16'(w));
    cs_start();
    spi_bits(hdr, 32, rx);
    for (int w = 0; w < words; w++) begin
      spi_bits(32'h0, 32, rx);
      n_vec++;
      if (rx !== 32'h0000_A000 + {16'h0, base} + 32'(w)) begin
        n_err++;
        $display("FAIL %s_word%0d got %h required %h", name, w, rx, 32'h0000_A000 + {16'h0, base} + 32'(w));
      end
    end
    cs_end();
    check_idle_counts(name, fd0, ab0, 1, 0);
  endtask

  task automatic test_abort();
    int fd0 = n_fd, ab0 = n_ab, wr0 = n_wr;
    cs_start();
    spi_bits(32'h8000_0040, 32, rx);
    spi_bits(32'h0001_5A5A, 17, rx);
    cs_end();
    n_vec++;
    if (n_wr - wr0 !== 0) begin
      n_err++;
      $display("FAIL abort_nowrite got writes=%0d required 0", n_wr - wr0);
    end
    check_idle_counts("abort", fd0, ab0, 0, 1);
    fd0 = n_fd; ab0 = n_ab;
    exp_wr_q.push_back({16'h0050, 32'hCAFEF00D});
    cs_start();
    spi_bits(32'h8000_0050, 32, rx);
    spi_bits(32'hCAFEF00D, 32, rx);
    cs_end();
    check_idle_counts("after_abort", fd0, ab0, 1, 0);
  endtask

  task automatic test_overrun();
    int fd0 = n_fd, ab0 = n_ab, wr0 = n_wr;
    n_miso_hi = 0;
    exp_wr_q.push_back({16'h0060, 32'h0BADF00D});
    cs_start();
    spi_bits(32'h8000_0060, 32, rx);
    spi_bits(32'h0BADF00D, 32, rx);
    spi_bits($urandom, 32, rx);
    spi_bits($urandom, 8, rx);
    cs_end();
    n_vec++;
    if (n_wr - wr0 !== 1 || n_miso_hi !== 0) begin
      n_err++;
      $display("FAIL overrun got writes=%0d miso_hi=%0d required 1/0", n_wr - wr0, n_miso_hi);
    end
    check_idle_counts("overrun", fd0, ab0, 1, 0);
  endtask

  task automatic test_wrap();
    int fd0 = n_fd, ab0 = n_ab;
    exp_wr_q.push_back({16'hFFFF, 32'h11111111});
    exp_wr_q.push_back({16'h0000, 32'h22222222});
    cs_start();
    spi_bits(32'h8001_FFFF, 32, rx);
    spi_bits(32'h11111111, 32, rx);
    spi_bits(32'h22222222, 32, rx);
    cs_end();
    check_idle_counts("wrap", fd0, ab0, 1, 0);
  endtask

  task automatic test_reset_midframe();
    int ab0 = n_ab;
    exp_rd_q.push_back(16'h0030);
    cs_start();
    spi_bits(32'h0000_0030, 32, rx);
    spi_bits(32'h0, 8, rx);
    rst_n = 1'b0;
    clk_n(3);
    n_vec++;
    if ({spi_miso, mem_if.wr_en, mem_if.rd_en, busy, frame_done, abort} !== 6'b0 ||
        {mem_if.wr_addr, mem_if.rd_addr, mem_if.wr_data} !== 64'h0) begin
      n_err++;
      $display("FAIL midreset_outputs got %b %h/%h/%h required all 0",
               {spi_miso, mem_if.wr_en, mem_if.rd_en, busy, frame_done, abort},
               mem_if.wr_addr, mem_if.rd_addr, mem_if.wr_data);
    end
    spi_cs = 1'b1;
    clk_n(4);
    rst_n = 1'b1;
    clk_n(12);
    n_vec++;
    if (busy !== 1'b0 || n_ab - ab0 !== 0 || exp_rd_q.size() != 0) begin
      n_err++;
      $display("FAIL midreset_release got busy=%b aborts=%0d rd_left=%0d required 0/0/0",
               busy, n_ab - ab0, exp_rd_q.size());
    end
    test_read_burst(16'h0070, 2, "read_after_reset");
  endtask

  initial begin
    test_reset();
    test_write_burst();
    test_read_burst(16'h0020, 3, "read");
    test_abort();
    test_overrun();
    test_wrap();
    test_reset_midframe();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
